// File: rtl/bcd_scan_display.sv
// Five-digit multiplexed 7-segment driver: double-buffered BCD input, one digit per slot,
// frame-boundary updates, leading-zero blanking and a dark cycle between digits.
module bcd_scan_display #(
    parameter int PRESCALE       = 50000,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit AN_ACTIVE_LOW  = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] tenthousands,
    input  logic [3:0] thousands,
    input  logic [3:0] hundreds,
    input  logic [3:0] tens,
    input  logic [3:0] ones,
    input  logic       din_valid,
    input  logic       lzb_en,
    output logic [4:0] an,
    output logic [6:0] seg,
    output logic       frame_done
);
    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    logic [PW-1:0]   r_pcnt;
    logic [2:0]      r_idx;
    logic [4:0][3:0] r_shadow;
    logic [4:0][3:0] r_active;
    logic            r_pending;
    logic [4:0]      r_an_h;
    logic [6:0]      r_seg_h;
    logic            r_frame_done;

    logic            w_tick;
    logic            w_wrap;
    logic [4:0][3:0] w_din;
    logic [3:0]      w_digit;
    logic            w_blank;
    logic [6:0]      w_enc;

    assign w_tick = (r_pcnt == PW'(PRESCALE - 1));
    assign w_wrap = w_tick && (r_idx == 3'd4);
    assign w_din  = {tenthousands, thousands, hundreds, tens, ones};

    // A digit is blanked when it and every digit to its left are zero; ones never blanks.
    always_comb begin
        w_digit = 4'd0;
        case (r_idx)
            3'd0:    w_digit = r_active[0];
            3'd1:    w_digit = r_active[1];
            3'd2:    w_digit = r_active[2];
            3'd3:    w_digit = r_active[3];
            3'd4:    w_digit = r_active[4];
            default: w_digit = 4'd0;
        endcase
        w_blank = lzb_en && (r_idx != 3'd0);
        for (int k = 0; k < 5; k++) begin
            if ((3'(k) >= r_idx) && (r_active[k] != 4'd0)) w_blank = 1'b0;
        end
    end

    always_comb begin
        w_enc = 7'h40;
        case (w_digit)
            4'd0:    w_enc = 7'h3F;
            4'd1:    w_enc = 7'h06;
            4'd2:    w_enc = 7'h5B;
            4'd3:    w_enc = 7'h4F;
            4'd4:    w_enc = 7'h66;
            4'd5:    w_enc = 7'h6D;
            4'd6:    w_enc = 7'h7D;
            4'd7:    w_enc = 7'h07;
            4'd8:    w_enc = 7'h7F;
            4'd9:    w_enc = 7'h6F;
            default: w_enc = 7'h40;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pcnt       <= '0;
            r_idx        <= 3'd0;
            r_an_h       <= '0;
            r_seg_h      <= '0;
            r_frame_done <= 1'b0;
        end else begin
            r_pcnt       <= w_tick ? '0 : r_pcnt + PW'(1);
            r_frame_done <= w_wrap;
            if (w_tick) begin
                // Dark cycle while the anode moves, so the old segments never ghost onto the next digit.
                r_idx   <= w_wrap ? 3'd0 : r_idx + 3'd1;
                r_an_h  <= '0;
                r_seg_h <= '0;
            end else begin
                r_an_h  <= 5'd1 << r_idx;
                r_seg_h <= w_blank ? 7'h00 : w_enc;
            end
        end
    end

    // Shadow captures any time; active only changes at a frame wrap so frames are never torn.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shadow  <= '0;
            r_active  <= '0;
            r_pending <= 1'b0;
        end else begin
            if (w_wrap && r_pending) r_active <= r_shadow;
            if (din_valid) begin
                r_shadow  <= w_din;
                r_pending <= 1'b1;
            end else if (w_wrap) begin
                r_pending <= 1'b0;
            end
        end
    end

    assign an         = AN_ACTIVE_LOW  ? ~r_an_h  : r_an_h;
    assign seg        = SEG_ACTIVE_LOW ? ~r_seg_h : r_seg_h;
    assign frame_done = r_frame_done;
endmodule

// File: tb/tb_bcd_scan_display.sv
// Bench for bcd_scan_display at PRESCALE=4: a frame-level reference model checks every cycle,
// plus table vectors, a wrap-edge load sequence and a mid-slot reset.
module tb_bcd_scan_display;
    localparam int P = 4;

    typedef struct packed {
        logic [19:0] dig;   // {tenthousands, thousands, hundreds, tens, ones}
        logic        lzb;
        logic [34:0] segs;  // expected seg per slot, slot 4 in the top bits
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] tenthousands = '0, thousands = '0, hundreds = '0, tens = '0, ones = '0;
    logic       din_valid = 1'b0;
    logic       lzb_en = 1'b0;
    logic [4:0] an;
    logic [6:0] seg;
    logic       frame_done;

    int         pass_cnt = 0;
    int         total = 0;
    int         edge_n = 0;
    logic [3:0] latest [5];
    logic [3:0] shown  [5];
    vec_t       tbl [6];

    bcd_scan_display #(.PRESCALE(P), .SEG_ACTIVE_LOW(1'b1), .AN_ACTIVE_LOW(1'b1)) dut (
        .clk(clk), .rst_n(rst_n),
        .tenthousands(tenthousands), .thousands(thousands), .hundreds(hundreds),
        .tens(tens), .ones(ones),
        .din_valid(din_valid), .lzb_en(lzb_en),
        .an(an), .seg(seg), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] font(input logic [3:0] d);
        logic [6:0] f;
        case (d)
            4'd0: f = 7'h3F; 4'd1: f = 7'h06; 4'd2: f = 7'h5B; 4'd3: f = 7'h4F;
            4'd4: f = 7'h66; 4'd5: f = 7'h6D; 4'd6: f = 7'h7D; 4'd7: f = 7'h07;
            4'd8: f = 7'h7F; 4'd9: f = 7'h6F;
            default: f = 7'h40;
        endcase
        return f;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
    endtask

    task automatic model_reset();
        edge_n = 0;
        for (int i = 0; i < 5; i++) begin
            latest[i] = 4'd0;
            shown[i]  = 4'd0;
        end
    endtask

    // One clock edge: the model derives slot/phase from the edge count since reset.
    task automatic cyc();
        int         pc, sl;
        logic       blank, ef;
        logic [4:0] ea;
        logic [6:0] es;
        @(posedge clk);
        pc = edge_n % P;
        sl = (edge_n / P) % 5;
        ef = (pc == P - 1) && (sl == 4);
        if (ef) shown = latest;
        if (din_valid) latest = '{ones, tens, hundreds, thousands, tenthousands};
        if (pc == P - 1) begin
            ea = 5'h1F;
            es = 7'h7F;
        end else begin
            blank = lzb_en && (sl > 0);
            for (int j = sl; j < 5; j++) if (shown[j] != 4'd0) blank = 1'b0;
            ea = 5'h1F & ~(5'd1 << sl);
            es = blank ? 7'h7F : ~font(shown[sl]);
        end
        edge_n++;
        @(negedge clk);
        chk("an", an, ea);
        chk("seg", seg, es);
        chk("frame_done", frame_done, ef);
    endtask

    task automatic to_phase(input int ph);
        int n = 0;
        while ((edge_n % (5 * P)) != ph && n < 50) begin
            cyc();
            n++;
        end
        if (n >= 50) chk("to_phase_timeout", n, 0);
    endtask

    task automatic load(input logic [19:0] d);
        {tenthousands, thousands, hundreds, tens, ones} = d;
        din_valid = 1'b1;
        cyc();
        din_valid = 1'b0;
    endtask

    initial begin
        int n;
        tbl[0] = '{20'h12345, 1'b0, {7'h79, 7'h24, 7'h30, 7'h19, 7'h12}};
        tbl[1] = '{20'h00042, 1'b1, {7'h7F, 7'h7F, 7'h7F, 7'h19, 7'h24}};
        tbl[2] = '{20'h00000, 1'b1, {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h40}};
        tbl[3] = '{20'h000B0, 1'b1, {7'h7F, 7'h7F, 7'h7F, 7'h3F, 7'h40}};
        tbl[4] = '{20'h98760, 1'b1, {7'h10, 7'h00, 7'h78, 7'h02, 7'h40}};
        tbl[5] = '{20'h00F00, 1'b1, {7'h7F, 7'h7F, 7'h3F, 7'h40, 7'h40}};
        model_reset();

        #3;
        chk("reset_an", an, 5'h1F);
        chk("reset_seg", seg, 7'h7F);
        chk("reset_fd", frame_done, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        cyc();
        chk("first_slot_an", an, 5'h1E);
        chk("first_slot_seg", seg, 7'h40);
        for (int f = 0; f < 2; f++) begin
            n = (f == 0) ? 1 : 0;
            do begin
                cyc();
                n++;
            end while (!frame_done && n < 100);
            chk("fd_period", n, 20);
        end

        foreach (tbl[i]) begin
            lzb_en = tbl[i].lzb;
            to_phase(10);
            load(tbl[i].dig);
            to_phase(0);
            for (int k = 0; k < 5; k++) begin
                to_phase(4 * k + 2);
                chk($sformatf("tbl%0d_an%0d", i, k), an, 5'h1F & ~(5'd1 << k));
                chk($sformatf("tbl%0d_seg%0d", i, k), seg, tbl[i].segs[k*7 +: 7]);
            end
        end

        // Value A mid-frame, value B on the exact wrap edge.
        lzb_en = 1'b0;
        to_phase(5);
        load(20'h12345);
        to_phase(19);
        load(20'h67890);
        to_phase(2);
        chk("wrapA_ones", seg, 7'h12);
        to_phase(18);
        chk("wrapA_tenthousands", seg, 7'h79);
        to_phase(2);
        chk("wrapB_ones", seg, 7'h40);
        to_phase(18);
        chk("wrapB_tenthousands", seg, 7'h02);

        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(0, 7) == 0) begin
                tenthousands = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
                thousands    = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
                hundreds     = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
                tens         = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
                ones         = 4'($urandom_range(0, 15));
                din_valid    = 1'b1;
            end else begin
                din_valid = 1'b0;
            end
            if ($urandom_range(0, 31) == 0) lzb_en = ~lzb_en;
            cyc();
        end
        din_valid = 1'b0;

        // Asynchronous reset in the middle of slot 3.
        lzb_en = 1'b0;
        load(20'h55555);
        to_phase(0);
        to_phase(14);
        chk("pre_reset_an", an, 5'h17);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_reset_an", an, 5'h1F);
        chk("async_reset_seg", seg, 7'h7F);
        chk("async_reset_fd", frame_done, 1'b0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        cyc();
        chk("restart_an", an, 5'h1E);
        chk("restart_seg", seg, 7'h40);
        to_phase(14);
        chk("restart_slot3_seg", seg, 7'h40);

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end
endmodule
